multiplicacion_secuencial: RTL and testbench
============================================

Name: multiplicacion_secuencial

Overview:
- Unsigned M-bit by M-bit multiplier using iterative shift-and-add, producing a 2M-bit product.
- Addition is the inverse of the ALU's subtract path. This block reuses the same ripple full-adder cell chain, operated over M clock cycles, instead of building a combinational array.
- Sits beside the combinational ALU operations as its multi-cycle arithmetic unit, with a start/busy/done handshake toward the controller.

Parameters:
- M, 4, operand width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge; only acted on in IDLE or DONE.
- A  input  M  multiplicand; captured when start is accepted.
- B  input  M  multiplier; captured when start is accepted.
- P  output  2M  product; valid from the done cycle; held until the next accepted start.
- busy  output  1  high while iterating (state CALC).
- done  output  1  one-cycle pulse: P and flags valid.
- Z  output  1  product equals zero.
- V  output  1  product does not fit in M bits (P[2M-1:M] != 0).

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, P=0, busy=0, done=0, Z=0, V=0, iteration counter=0, internal registers cleared.
- Any in-flight operation is abandoned on reset; no done pulse follows.
- Internal registers:
  - mcand (M bits)
  - acc_hi (M bits)
  - acc_lo (M bits, initialised with B)
  - cnt (ceil(log2(M+1)) bits)
- States:
  - IDLE: busy=0, done=0. On start=1: mcand<=A, acc_hi<=0, acc_lo<=B, cnt<=0, go to CALC.
  - CALC: busy=1. Each cycle: sum = acc_hi + (acc_lo[0] ? mcand : 0), giving M bits plus carry-out c. Then {acc_hi,acc_lo} <= {c, sum, acc_lo[M-1:1]} (logical right shift of the combined value). cnt<=cnt+1. After the M-th CALC cycle (cnt==M-1), go to DONE.
  - DONE: on entry, P<={acc_hi,acc_lo}, Z=(product==0), V=(upper M bits !=0); done=1 for exactly this cycle, busy=0. If start=1: capture operands and go to CALC (back-to-back, no idle gap). Otherwise go to IDLE.
- Latency: start sampled at edge k puts state in CALC for edges k+1..k+M; done is high in the cycle following edge k+M. Throughput is one result per M+1 cycles.
- start is ignored while in CALC; operands are not re-captured.
- A/B changes after capture have no effect on the operation in flight.
- P, Z and V change only on DONE entry or reset. They keep their previous values through IDLE and CALC.
- Width rule: the adder is exactly M bits wide with carry-out. The carry is shifted into acc_hi[M-1], so no intermediate overflow is possible; the maximum product (2^M-1)^2 fits in 2M bits.
- Zero multiplier: the block still runs the full M cycles (fixed latency, no early exit).

Decomposition:
- Shared package alu_pkg:
  - state enum mul_state_t {IDLE, CALC, DONE}, 2-bit encoded.
  - Constant MUL_DEFAULT_M = 4.
- One sub-module, sumador_nbits (parameter M): M chained single-bit full adders; ports A[M-1:0], B[M-1:0], cin, R[M-1:0], cout. Instantiated once with cin=0.
- FSM and datapath registers stay in the top module.

Test Plan:
- M=4; A=3, B=5, pulse start -> busy high 4 cycles; done pulse 5 cycles after start edge; P=8'h0F, Z=0, V=0.
- M=4; A=15, B=15 -> P=8'hE1, V=1, Z=0; exercises carry-out of every add.
- M=4; A=0, B=9, then A=9, B=0 -> P=8'h00, Z=1, V=0 both times; latency still 5 cycles.
- Start held high through CALC with A/B changed mid-operation -> first result uses originally captured operands. Start seen in the DONE cycle launches the second operation immediately; its done arrives 5 cycles after the first done.
- rst_n pulsed low during CALC cycle 2 -> outputs immediately 0 (asynchronous); no done pulse. Next start with A=7, B=6 -> P=8'h2A.
- Random sweep of all 256 operand pairs at M=4, plus 1000 random pairs at M=8 -> P equals A*B, V equals (A*B >= 2^M), Z equals (A*B == 0).

Source files
------------

// File: rtl/multiplicacion_secuencial_pkg.sv
// alu_pkg: shared types and constants for the ALU's multi-cycle arithmetic unit.
package alu_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;
    localparam int MUL_DEFAULT_M = 4;
endpackage

// File: rtl/multiplicacion_secuencial_if.sv
// multiplicacion_secuencial_if: start/busy/done handshake plus operands and product flags.
interface multiplicacion_secuencial_if
    import alu_pkg::*;
#(
    parameter int M = MUL_DEFAULT_M
);
    logic           start;
    logic [M-1:0]   A;
    logic [M-1:0]   B;
    logic [2*M-1:0] P;
    logic           busy;
    logic           done;
    logic           Z;
    logic           V;
    modport master (output start, A, B, input P, busy, done, Z, V);
    modport slave  (input start, A, B, output P, busy, done, Z, V);
endinterface

// File: rtl/multiplicacion_secuencial_sumador.sv
// sumador_nbits: M-bit ripple-carry adder built from chained single-bit full adders.
module sumador_nbits #(
    parameter int M = 4
) (
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    input  logic         cin,
    output logic [M-1:0] R,
    output logic         cout
);
    logic [M:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < M; i++) begin : g_fa
        assign R[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    assign cout = c[M];
endmodule

// File: rtl/multiplicacion_secuencial.sv
// multiplicacion_secuencial: unsigned MxM shift-and-add multiplier, one partial product per cycle.
module multiplicacion_secuencial
    import alu_pkg::*;
#(
    parameter int M = MUL_DEFAULT_M
) (
    input logic                        clk,
    input logic                        rst_n,
    multiplicacion_secuencial_if.slave bus
);
    localparam int CW = $clog2(M + 1);
    mul_state_t     state_q, state_d;
    logic [M-1:0]   mcand_q, mcand_d;
    logic [M-1:0]   acc_hi_q, acc_hi_d;
    logic [M-1:0]   acc_lo_q, acc_lo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*M-1:0] p_q, p_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           z_q, z_d;
    logic           v_q, v_d;
    logic [M-1:0]   addend;
    logic [M-1:0]   sum;
    logic           carry;
    logic [2*M-1:0] shifted;
    assign addend  = acc_lo_q[0] ? mcand_q : '0;
    // Carry lands in the top bit of acc_hi, so the combined shift never loses a bit.
    assign shifted = {carry, sum, acc_lo_q[M-1:1]};
    sumador_nbits #(.M(M)) u_sumador (
        .A   (acc_hi_q),
        .B   (addend),
        .cin (1'b0),
        .R   (sum),
        .cout(carry)
    );
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        z_d      = z_q;
        v_d      = v_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        if (state_q == CALC) begin
            {acc_hi_d, acc_lo_d} = shifted;
            cnt_d  = cnt_q + CW'(1);
            busy_d = 1'b1;
            if (cnt_q == CW'(M - 1)) begin
                state_d = DONE;
                p_d     = shifted;
                z_d     = shifted == '0;
                v_d     = |shifted[2*M-1:M];
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else if (bus.start) begin
            state_d  = CALC;
            mcand_d  = bus.A;
            acc_hi_d = '0;
            acc_lo_d = bus.B;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            z_q      <= z_d;
            v_q      <= v_d;
        end
    end
    assign bus.P    = p_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Z    = z_q;
    assign bus.V    = v_q;
endmodule

// File: tb/tb_multiplicacion_secuencial.sv
// tb_multiplicacion_secuencial: scoreboard bench for M=4 and M=8 instances against plain A*B.
module tb_multiplicacion_secuencial;
    typedef struct {
        logic [15:0] p;
        logic        z;
        logic        v;
        int          cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    logic [7:0]  last4 = '0;
    logic [15:0] last8 = '0;
    int   run4 = 0;
    int   run8 = 0;
    multiplicacion_secuencial_if #(.M(4)) if4 ();
    multiplicacion_secuencial_if #(.M(8)) if8 ();
    multiplicacion_secuencial #(.M(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    multiplicacion_secuencial #(.M(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask
    // Expected result straight from arithmetic; done is due M+1 negedges after the drive.
    function automatic exp_t model(input int m, input int a, input int b, input int c);
        exp_t e;
        int   p;
        p     = a * b;
        e.p   = 16'(p);
        e.z   = p == 0;
        e.v   = p >= (1 << m);
        e.cyc = c + m + 1;
        return e;
    endfunction
    always @(negedge clk) begin
        if (!rst_n) begin
            last4 = '0;
            run4  = 0;
        end else begin
            if (if4.busy) run4++;
            if (if4.done) begin
                if (q4.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL m4_unexpected_done: got P=%0h expected no done", if4.P);
                end else begin
                    e4 = q4.pop_front();
                    chk("m4_P", 32'(if4.P), 32'(e4.p));
                    chk("m4_Z", 32'(if4.Z), 32'(e4.z));
                    chk("m4_V", 32'(if4.V), 32'(e4.v));
                    chk("m4_latency", cyc, e4.cyc);
                    chk("m4_busy_cycles", run4, 4);
                end
                last4 = if4.P;
                run4  = 0;
            end else chk("m4_P_hold", 32'(if4.P), 32'(last4));
        end
    end
    always @(negedge clk) begin
        if (!rst_n) begin
            last8 = '0;
            run8  = 0;
        end else begin
            if (if8.busy) run8++;
            if (if8.done) begin
                if (q8.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL m8_unexpected_done: got P=%0h expected no done", if8.P);
                end else begin
                    e8 = q8.pop_front();
                    chk("m8_P", 32'(if8.P), 32'(e8.p));
                    chk("m8_Z", 32'(if8.Z), 32'(e8.z));
                    chk("m8_V", 32'(if8.V), 32'(e8.v));
                    chk("m8_latency", cyc, e8.cyc);
                    chk("m8_busy_cycles", run8, 8);
                end
                last8 = if8.P;
                run8  = 0;
            end else chk("m8_P_hold", 32'(if8.P), 32'(last8));
        end
    end
    task automatic wait_done4();
        int t = 0;
        while (!if4.done && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!if4.done) begin
            tests++;
            fails++;
            $display("FAIL m4_timeout: got no done expected done within 20 cycles");
        end
    endtask
    task automatic wait_done8();
        int t = 0;
        while (!if8.done && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (!if8.done) begin
            tests++;
            fails++;
            $display("FAIL m8_timeout: got no done expected done within 30 cycles");
        end
    endtask
    task automatic go4(input int a, input int b);
        if4.start = 1'b1;
        if4.A     = a[3:0];
        if4.B     = b[3:0];
        q4.push_back(model(4, a, b, cyc));
        @(negedge clk);
        if4.start = 1'b0;
        wait_done4();
    endtask
    task automatic go8(input int a, input int b);
        if8.start = 1'b1;
        if8.A     = a[7:0];
        if8.B     = b[7:0];
        q8.push_back(model(8, a, b, cyc));
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8();
    endtask
    initial begin
        if4.start = 1'b0;
        if4.A     = '0;
        if4.B     = '0;
        if8.start = 1'b0;
        if8.A     = '0;
        if8.B     = '0;
        repeat (2) @(negedge clk);
        chk("rst_P4", 32'(if4.P), 0);
        chk("rst_busy4", 32'(if4.busy), 0);
        chk("rst_done4", 32'(if4.done), 0);
        chk("rst_Z4", 32'(if4.Z), 0);
        chk("rst_V4", 32'(if4.V), 0);
        chk("rst_P8", 32'(if8.P), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        go4(3, 5);
        go4(15, 15);
        go4(0, 9);
        go4(9, 0);
        repeat (2) @(negedge clk);
        // Start held through CALC with operands changed; DONE-cycle start launches the next op.
        if4.start = 1'b1;
        if4.A     = 4'd3;
        if4.B     = 4'd4;
        q4.push_back(model(4, 3, 4, cyc));
        @(negedge clk);
        if4.A = 4'd15;
        if4.B = 4'd15;
        wait_done4();
        q4.push_back(model(4, 15, 15, cyc));
        @(negedge clk);
        if4.start = 1'b0;
        wait_done4();
        // Abort an operation with reset in its second CALC cycle.
        go4(5, 3);
        if4.start = 1'b1;
        if4.A     = 4'd5;
        if4.B     = 4'd3;
        q4.push_back(model(4, 5, 3, cyc));
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_P", 32'(if4.P), 0);
        chk("async_rst_busy", 32'(if4.busy), 0);
        chk("async_rst_done", 32'(if4.done), 0);
        chk("async_rst_Z", 32'(if4.Z), 0);
        chk("async_rst_V", 32'(if4.V), 0);
        q4.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        go4(7, 6);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                go4(a, b);
            end
        end
        go8(255, 255);
        go8(0, 200);
        go8(16, 16);
        go8(15, 17);
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            go8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        repeat (12) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
